// File: rtl/eth_video_framer.sv
// eth_video_framer: buffers 32-bit Ethernet pixel words in a small FIFO and
// plays them out against a fixed raster, with registered RGB/DE/sync outputs.
//
// Ports:
//   clk, rst          - pixel clock, synchronous active-high reset
//   eth_data_in       - pixel word, R=[31:24] G=[23:16] B=[15:8]
//   eth_valid         - write strobe, no backpressure
//   run               - raster enable; low holds the counters at origin
//   clr_flags         - clears the sticky overflow/underflow flags
//   vid_r/g/b, vid_de - registered pixel colour and data enable
//   vid_hsync/vsync   - registered syncs, polarity set by SYNC_ACTIVE_LOW
//   fifo_level        - FIFO occupancy, 0..FIFO_DEPTH
//   overflow          - sticky: a word was dropped on a full FIFO
//   underflow         - sticky: an active pixel found the FIFO empty
module eth_video_framer #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int FIFO_DEPTH      = 16,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   eth_data_in,
  input  logic                          eth_valid,
  input  logic                          run,
  input  logic                          clr_flags,
  output logic [7:0]                    vid_r,
  output logic [7:0]                    vid_g,
  output logic [7:0]                    vid_b,
  output logic                          vid_de,
  output logic                          vid_hsync,
  output logic                          vid_vsync,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;

  // Compare one bit wider than the counters so boundary constants
  // equal to the total never truncate.
  localparam logic [HW:0] H_ACT_C = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] H_HS_B  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] H_HS_E  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW:0] V_ACT_C = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] V_VS_B  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] V_VS_E  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  localparam logic SYNC_ON  = ~SYNC_ACTIVE_LOW;
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [23:0]   mem_q [FIFO_DEPTH];

  logic active;
  logic in_hs;
  logic in_vs;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic unused_low_byte;

  assign unused_low_byte = ^eth_data_in[7:0];

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_comb begin
    active = run
           && ({1'b0, h_q} < H_ACT_C)
           && ({1'b0, v_q} < V_ACT_C);
    in_hs  = ({1'b0, h_q} >= H_HS_B)
           && ({1'b0, h_q} < H_HS_E);
    in_vs  = ({1'b0, v_q} >= V_VS_B)
           && ({1'b0, v_q} < V_VS_E);
    empty  = (lvl_q == '0);
    full   = (lvl_q == LVL_FULL);
    // A pop frees a slot this cycle, so a full FIFO
    // can still accept the incoming word.
    pop    = active && !empty;
    push   = eth_valid && (!full || pop);
  end

  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    lvl_d = lvl_q;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_comb begin
    rgb_d = pop ? mem_q[rd_q] : '0;
    de_d  = active;
    hs_d  = in_hs ? SYNC_ON : SYNC_OFF;
    vs_d  = in_vs ? SYNC_ON : SYNC_OFF;
  end

  // Set events take priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (eth_valid && !push) begin
      ovf_d = 1'b1;
    end else if (clr_flags) begin
      ovf_d = 1'b0;
    end
    if (active && empty) begin
      udf_d = 1'b1;
    end else if (clr_flags) begin
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= eth_data_in[31:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= SYNC_OFF;
      vs_q  <= SYNC_OFF;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      rgb_q <= rgb_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign vid_r      = rgb_q[23:16];
  assign vid_g      = rgb_q[15:8];
  assign vid_b      = rgb_q[7:0];
  assign vid_de     = de_q;
  assign vid_hsync  = hs_q;
  assign vid_vsync  = vs_q;
  assign fifo_level = lvl_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_eth_video_framer.sv
// Directed bench for eth_video_framer on a tiny 8x5 raster, 4-entry FIFO.
// Steps run linearly; outputs are sampled 1 time unit after each edge.
module tb_eth_video_framer;

  logic        clk;
  logic        rst;
  logic [31:0] eth_data_in;
  logic        eth_valid;
  logic        run;
  logic        clr_flags;
  logic [7:0]  vid_r;
  logic [7:0]  vid_g;
  logic [7:0]  vid_b;
  logic        vid_de;
  logic        vid_hsync;
  logic        vid_vsync;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        underflow;

  int n_assert;
  int n_fail;

  eth_video_framer #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FIFO_DEPTH(4), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .eth_data_in(eth_data_in),
    .eth_valid(eth_valid),
    .run(run),
    .clr_flags(clr_flags),
    .vid_r(vid_r),
    .vid_g(vid_g),
    .vid_b(vid_b),
    .vid_de(vid_de),
    .vid_hsync(vid_hsync),
    .vid_vsync(vid_vsync),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, vid_r, vid_g, vid_b};
  endfunction

  logic [31:0] ord_w [4];
  logic [31:0] ord_e [4];
  logic [7:0]  bv;
  logic [31:0] mid_e [4];
  logic [31:0] mid_l [6];

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    ord_w[0] = 32'hFF000000; ord_e[0] = 32'hFF0000;
    ord_w[1] = 32'h00FF0000; ord_e[1] = 32'h00FF00;
    ord_w[2] = 32'h0000FF00; ord_e[2] = 32'h0000FF;
    ord_w[3] = 32'h12345600; ord_e[3] = 32'h123456;
    mid_e[0] = 32'h050505;   mid_e[1] = 32'h101010;
    mid_e[2] = 32'h111111;   mid_e[3] = 32'h121212;
    mid_l[0] = 1; mid_l[1] = 1; mid_l[2] = 1;
    mid_l[3] = 1; mid_l[4] = 2; mid_l[5] = 3;

    // Reset with writes attempted
    rst = 1'b1; eth_valid = 1'b1;
    eth_data_in = 32'hAABBCC00;
    run = 1'b0; clr_flags = 1'b0;
    repeat (3) step();
    chk("rst_rgb", rgb(), 32'h0);
    chk("rst_de", {31'b0, vid_de}, 0);
    chk("rst_hs", {31'b0, vid_hsync}, 1);
    chk("rst_vs", {31'b0, vid_vsync}, 1);
    chk("rst_lvl", {29'b0, fifo_level}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    chk("rst_udf", {31'b0, underflow}, 0);
    rst = 1'b0; eth_valid = 1'b0;
    step();
    chk("rst_nostore", {29'b0, fifo_level}, 0);

    // Ordered playout
    for (int i = 0; i < 4; i++) begin
      eth_valid = 1'b1; eth_data_in = ord_w[i];
      step();
      chk("ord_fill", {29'b0, fifo_level}, i + 1);
    end
    eth_valid = 1'b0; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ord_de", {31'b0, vid_de}, 1);
      chk("ord_rgb", rgb(), ord_e[i]);
      chk("ord_lvl", {29'b0, fifo_level}, 3 - i);
    end
    step();
    chk("ord_de_off", {31'b0, vid_de}, 0);
    chk("ord_rgb_off", rgb(), 0);
    chk("ord_ovf", {31'b0, overflow}, 0);
    chk("ord_udf", {31'b0, underflow}, 0);
    run = 1'b0;
    step(); step();

    // Overflow: fifth word dropped
    for (int i = 0; i < 5; i++) begin
      bv = 8'(8'h11 * (i + 1));
      eth_valid = 1'b1; eth_data_in = {bv, bv, bv, 8'h00};
      step();
      chk("ovf_lvl", {29'b0, fifo_level}, (i < 4) ? i + 1 : 4);
      chk("ovf_flag", {31'b0, overflow}, (i == 4) ? 1 : 0);
    end
    eth_valid = 1'b0; clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ovf_clr", {31'b0, overflow}, 0);
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bv = 8'(8'h11 * (i + 1));
      step();
      chk("ovf_rgb", rgb(), {8'h00, bv, bv, bv});
    end
    step();
    chk("ovf_de_off", {31'b0, vid_de}, 0);
    chk("ovf_rgb_off", rgb(), 0);
    chk("ovf_empty", {29'b0, fifo_level}, 0);
    run = 1'b0;
    step(); step();

    // Underflow; set beats a same-cycle clear
    run = 1'b1; clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("udf_de", {31'b0, vid_de}, 1);
    chk("udf_rgb", rgb(), 0);
    chk("udf_flag", {31'b0, underflow}, 1);
    eth_valid = 1'b1; eth_data_in = 32'hABCDEF00;
    step();
    eth_valid = 1'b0;
    chk("udf_wr_rgb", rgb(), 0);
    chk("udf_wr_lvl", {29'b0, fifo_level}, 1);
    step();
    chk("udf_pop_rgb", rgb(), 32'hABCDEF);
    chk("udf_pop_lvl", {29'b0, fifo_level}, 0);
    step();
    chk("udf_black", rgb(), 0);
    chk("udf_de2", {31'b0, vid_de}, 1);
    step();
    chk("udf_de_off", {31'b0, vid_de}, 0);
    run = 1'b0; clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("udf_clr", {31'b0, underflow}, 0);
    step();

    // Full FIFO with simultaneous pop and write
    for (int i = 0; i < 4; i++) begin
      bv = 8'(i + 1);
      eth_valid = 1'b1; eth_data_in = {bv, bv, bv, 8'h00};
      step();
    end
    chk("full_lvl", {29'b0, fifo_level}, 4);
    run = 1'b1; eth_data_in = 32'h05050500;
    step();
    eth_valid = 1'b0;
    chk("full_rgb", rgb(), 32'h010101);
    chk("full_lvl_same", {29'b0, fifo_level}, 4);
    chk("full_ovf", {31'b0, overflow}, 0);
    for (int i = 2; i < 5; i++) begin
      bv = 8'(i);
      step();
      chk("full_rgb_n", rgb(), {8'h00, bv, bv, bv});
      chk("full_lvl_n", {29'b0, fifo_level}, 5 - i);
    end
    step();
    chk("full_de_off", {31'b0, vid_de}, 0);
    chk("full_left", {29'b0, fifo_level}, 1);
    run = 1'b0;
    step(); step();

    // Mid-line reset with fifo_level = 3
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bv = 8'(8'h10 + i);
      eth_valid = 1'b1; eth_data_in = {bv, bv, bv, 8'h00};
      step();
      if (i < 4) chk("mid_rgb", rgb(), mid_e[i]);
      chk("mid_lvl", {29'b0, fifo_level}, mid_l[i]);
    end
    chk("mid_hs_on", {31'b0, vid_hsync}, 0);
    chk("mid_de_off", {31'b0, vid_de}, 0);
    eth_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_lvl", {29'b0, fifo_level}, 0);
    chk("mrst_de", {31'b0, vid_de}, 0);
    chk("mrst_hs", {31'b0, vid_hsync}, 1);
    chk("mrst_vs", {31'b0, vid_vsync}, 1);
    chk("mrst_ovf", {31'b0, overflow}, 0);
    chk("mrst_udf", {31'b0, underflow}, 0);
    step();
    chk("mrst_origin_de", {31'b0, vid_de}, 1);
    chk("mrst_flushed", rgb(), 0);
    chk("mrst_udf2", {31'b0, underflow}, 1);

    // Raster: two frames from origin
    rst = 1'b1;
    step();
    rst = 1'b0;
    begin
      int de_cnt, hs_cnt, vs_cnt, fall0, fall1;
      int h, v;
      logic prev_vs;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      fall0 = -1; fall1 = -1;
      prev_vs = 1'b1;
      for (int k = 0; k < 80; k++) begin
        step();
        h = k % 8;
        v = (k / 8) % 5;
        chk("ras_de", {31'b0, vid_de},
            (h < 4 && v < 2) ? 1 : 0);
        chk("ras_hs", {31'b0, vid_hsync},
            (h >= 5 && h < 7) ? 0 : 1);
        chk("ras_vs", {31'b0, vid_vsync},
            (v == 3) ? 0 : 1);
        chk("ras_excl", {31'b0, vid_de & ~vid_hsync}, 0);
        if (vid_de) de_cnt++;
        if (!vid_hsync) hs_cnt++;
        if (!vid_vsync) vs_cnt++;
        if (prev_vs && !vid_vsync) begin
          if (fall0 < 0) fall0 = k;
          else if (fall1 < 0) fall1 = k;
        end
        prev_vs = vid_vsync;
      end
      chk("ras_de_total", de_cnt, 16);
      chk("ras_hs_total", hs_cnt, 20);
      chk("ras_vs_total", vs_cnt, 16);
      chk("ras_vs_first", fall0, 24);
      chk("ras_period", fall1 - fall0, 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
